stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Registered N-channel stream multiplexer: the parametrised successor to the team's combinational 8:1 bit mux. It selects one of N_CH valid/ready input channels of DATA_W bits, either by an explicit select or by round-robin arbitration, and delivers the chosen beat through a one-entry output register with full valid/ready back-pressure. It sits between parallel producers and a single shared consumer.

## Interface
- N_CH, 8, number of input channels (≥2)
- DATA_W, 8, data width per channel (≥1)
- SEL_W, $clog2(N_CH), derived; select and channel-tag width (not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SEL_W  channel index used when mode = 0
- in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_valid  in  N_CH  per-channel valid
- in_ready  out  N_CH  per-channel ready; at most one bit high per cycle
- out_data  out  DATA_W  registered output beat
- out_ch  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer ready

## Operation
- Transfer occurs on any channel where valid & ready are both high at a rising edge.
- load_en = !out_valid | out_ready. The output register accepts a new beat when it is empty or is draining in the same cycle.
- Grant in fixed mode (mode=0): g = sel when sel < N_CH and in_valid[sel] = 1. Otherwise no grant. sel ≥ N_CH never grants.
- Grant in round-robin mode (mode=1): search starts at channel ptr+1 and proceeds upward with wrap to 0. The first channel with in_valid set wins. No grant if in_valid = 0.
- in_ready[g] = load_en & grant. All other in_ready bits are 0. in_ready is combinational from in_valid, mode, sel, out_valid and out_ready.
- On accept: out_data ← in_data[g], out_ch ← g, out_valid ← 1. In either mode, ptr ← g.
- If there is no accept and out_ready & out_valid, then out_valid ← 0. out_data and out_ch hold their values.
- With out_valid=1 and out_ready=0, out_data, out_ch and out_valid are held stable and all in_ready bits are 0.
- A mode change takes effect on the next arbitration. ptr is kept across mode changes.
- Inputs are not required to hold valid stable. The block never drops a beat once accepted.

## Timing
- Latency: input accept at edge k makes the beat visible on out_* after edge k, in cycle k+1.
- Throughput: 1 beat per cycle when out_ready stays high.
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_ch=0, ptr=N_CH-1, so channel 0 has first round-robin priority. While rst=1, in_ready is forced to all zeros.
- A reset asserted while out_valid=1 discards the held beat. No transfer completes on that edge.
- Simultaneous drain and load in the same edge: the new beat replaces the old one and out_valid stays 1.
- Round-robin wrap: with ptr=N_CH-1, the search order is 0,1,…,N_CH-1. A lone requester on any channel is granted every cycle.

## Structure
- A shared package holds MODE_FIXED=1'b0 and MODE_RR=1'b1.
- Sub-module stream_rr_arb contains the ptr register, the rotate-priority search, and the fixed/round-robin grant selection. Its outputs are grant_valid and grant_idx, and it takes an update strobe.
- The top level holds the output register, load_en, the in_ready decode and the data select.

## Test plan
- Fixed mode, DATA_W=8, N_CH=8: in_data channel i = 8'hA0+i, all valid, out_ready=1, sel stepped 0..7 -> out_data A0..A7 and out_ch 0..7, each one cycle after its select.
- Round-robin, all 8 valid continuously, out_ready=1 -> out_ch sequence 0,1,…,7,0,1 with one beat per cycle and exactly one in_ready high per cycle.
- Back-pressure: beat held, out_ready=0 for 5 cycles -> out_data and out_ch stable, out_valid=1, in_ready=0. Release -> held beat transfers, and the next beat loads in the same edge.
- Sparse round-robin: only channels 2 and 5 valid, ptr=5 -> grants alternate 2,5,2. sel=3'd7 in fixed mode with in_valid[7]=0 -> no grant and out_valid drops after drain.
- Reset mid-operation: rst for 1 cycle while out_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 during rst. Next round-robin grant with all valid goes to channel 0.
- Parameter sweep N_CH=3, DATA_W=16: round-robin wrap goes 0,1,2,0, and sel=3 never grants.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants for the stream_mux_rr slice: the arbitration mode encoding.
package stream_mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_rr_arb.sv
// Grant selection for stream_mux_rr: explicit select or rotating-priority search
// starting just after the last granted channel (ptr_reg).
module stream_rr_arb
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N_CH-1:0]  req,
  input  logic             update,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  localparam int             PAD_W = 1 << SEL_W;
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N_CH);

  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;
  logic [SEL_W-1:0] cand_idx [N_CH];
  logic [N_CH-1:0]  cand_hit;
  logic [PAD_W-1:0] req_pad;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             fixed_valid;

  // Padding to a power of two lets an out-of-range select read a zero request.
  always_comb begin
    req_pad = '0;
    req_pad[N_CH-1:0] = req;
  end

  assign fixed_valid = req_pad[sel];

  // Candidate gi is the channel (gi+1) places after ptr_reg, wrapped modulo N_CH.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
      localparam logic [SEL_W:0] OFF = (SEL_W+1)'(gi + 1);
      logic [SEL_W:0] sum;
      assign sum          = {1'b0, ptr_reg} + OFF;
      assign cand_idx[gi] = (sum >= N_EXT) ? SEL_W'(sum - N_EXT) : sum[SEL_W-1:0];
      assign cand_hit[gi] = req_pad[cand_idx[gi]];
    end
  endgenerate

  // Nearest candidate wins, so scan from the far end and let closer hits overwrite.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        rr_valid = 1'b1;
        rr_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
    end else begin
      grant_valid = fixed_valid;
      grant_idx   = sel;
    end
  end

  assign ptr_next = update ? grant_idx : ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= SEL_W'(N_CH - 1);
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N-channel valid/ready stream multiplexer with fixed-select or
// round-robin arbitration and a one-entry output register.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic              load_en;
  logic              accept;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] chan_data [N_CH];
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_next;
  logic [SEL_W-1:0]  ch_reg;
  logic [SEL_W-1:0]  ch_next;
  logic              valid_reg;
  logic              valid_next;

  stream_rr_arb #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .sel         (sel),
    .req         (in_valid),
    .update      (accept),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // The register can take a beat when empty or when its current beat leaves this edge.
  assign load_en = !valid_reg || out_ready;
  assign accept  = !rst && load_en && grant_valid;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*DATA_W +: DATA_W];
      assign in_ready[gi]  = accept && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    data_next  = data_reg;
    ch_next    = ch_reg;
    valid_next = valid_reg;
    if (accept) begin
      data_next = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (grant_idx == SEL_W'(i)) begin
          data_next = chan_data[i];
        end
      end
      ch_next    = grant_idx;
      valid_next = 1'b1;
    end else if (out_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      ch_reg    <= '0;
      valid_reg <= 1'b0;
    end else begin
      data_reg  <= data_next;
      ch_reg    <= ch_next;
      valid_reg <= valid_next;
    end
  end

  assign out_data  = data_reg;
  assign out_ch    = ch_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: an 8x8 instance and a 3x16 instance, checked every cycle
// against a transaction-level model plus table and hand-written scenarios.
module tb_stream_mux_rr;

  localparam int N8 = 8;
  localparam int W8 = 8;
  localparam int S8 = 3;
  localparam int N3 = 3;
  localparam int W3 = 16;
  localparam int S3 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              mode8;
  logic [S8-1:0]     sel8;
  logic [N8*W8-1:0]  in_data8;
  logic [N8-1:0]     in_valid8;
  logic [N8-1:0]     in_ready8;
  logic [W8-1:0]     out_data8;
  logic [S8-1:0]     out_ch8;
  logic              out_valid8;
  logic              out_ready8;

  logic              mode3;
  logic [S3-1:0]     sel3;
  logic [N3*W3-1:0]  in_data3;
  logic [N3-1:0]     in_valid3;
  logic [N3-1:0]     in_ready3;
  logic [W3-1:0]     out_data3;
  logic [S3-1:0]     out_ch3;
  logic              out_valid3;
  logic              out_ready3;

  stream_mux_rr #(.N_CH(N8), .DATA_W(W8)) dut8 (
    .clk(clk), .rst(rst), .mode(mode8), .sel(sel8), .in_data(in_data8),
    .in_valid(in_valid8), .in_ready(in_ready8), .out_data(out_data8),
    .out_ch(out_ch8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  stream_mux_rr #(.N_CH(N3), .DATA_W(W3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int tests = 0;
  int fails = 0;

  // Transaction-level model state: the beat currently held and the last granted channel.
  bit            m8_valid = 1'b0;
  logic [W8-1:0] m8_data  = '0;
  int            m8_ch    = 0;
  int            m8_ptr   = N8 - 1;
  bit            m3_valid = 1'b0;
  logic [W3-1:0] m3_data  = '0;
  int            m3_ch    = 0;
  int            m3_ptr   = N3 - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Channel that should win, or -1 when nobody is granted.
  function automatic int ref_grant(input int n, input bit mode, input int sel,
                                   input logic [7:0] valid, input int ptr);
    if (!mode) begin
      if (sel >= n) return -1;
      return valid[sel] ? sel : -1;
    end
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (ptr + k) % n;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: check in_ready before the edge, advance the model, check outputs after.
  task automatic tick();
    int g8, g3;
    bit acc8, acc3;
    logic [7:0] e8, e3;
    logic [W8-1:0] d8;
    logic [W3-1:0] d3;
    #1;
    g8   = ref_grant(N8, mode8, int'(sel8), in_valid8, m8_ptr);
    acc8 = !rst && (!m8_valid || out_ready8) && (g8 >= 0);
    e8   = acc8 ? 8'(1 << g8) : 8'h00;
    d8   = (g8 >= 0) ? in_data8[g8*W8 +: W8] : '0;
    g3   = ref_grant(N3, mode3, int'(sel3), {5'b0, in_valid3}, m3_ptr);
    acc3 = !rst && (!m3_valid || out_ready3) && (g3 >= 0);
    e3   = acc3 ? 8'(1 << g3) : 8'h00;
    d3   = (g3 >= 0) ? in_data3[g3*W3 +: W3] : '0;
    check("in_ready8", 32'(in_ready8), 32'(e8));
    check("in_ready3", 32'(in_ready3), 32'(e3[N3-1:0]));
    @(posedge clk);
    if (rst) begin
      m8_valid = 1'b0; m8_data = '0; m8_ch = 0; m8_ptr = N8 - 1;
      m3_valid = 1'b0; m3_data = '0; m3_ch = 0; m3_ptr = N3 - 1;
      $display("[TB] t=%0t reset", $time);
    end else begin
      if (acc8) begin
        m8_valid = 1'b1; m8_data = d8; m8_ch = g8; m8_ptr = g8;
        $display("[TB] t=%0t n8 accept ch=%0d data=%02h", $time, g8, d8);
      end else if (out_ready8) begin
        m8_valid = 1'b0;
      end
      if (acc3) begin
        m3_valid = 1'b1; m3_data = d3; m3_ch = g3; m3_ptr = g3;
        $display("[TB] t=%0t n3 accept ch=%0d data=%04h", $time, g3, d3);
      end else if (out_ready3) begin
        m3_valid = 1'b0;
      end
    end
    #1;
    check("out_valid8", 32'(out_valid8), 32'(m8_valid));
    check("out_data8",  32'(out_data8),  32'(m8_data));
    check("out_ch8",    32'(out_ch8),    32'(m8_ch));
    check("out_valid3", 32'(out_valid3), 32'(m3_valid));
    check("out_data3",  32'(out_data3),  32'(m3_data));
    check("out_ch3",    32'(out_ch3),    32'(m3_ch));
    @(negedge clk);
  endtask

  typedef struct {
    bit         mode;
    logic [2:0] sel;
    logic [7:0] valid;
    bit         oready;
    logic [7:0] exp_ready;
    bit         exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_ch;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Fixed-mode select sweep, then no-grant drain and back-pressure corners.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b0, 3'(i), 8'hFF, 1'b1, 8'(1 << i), 1'b1, 8'(8'hA0 + i), 3'(i)};
    end
    vecs[8]  = '{1'b0, 3'd7, 8'h7F, 1'b1, 8'h00, 1'b0, 8'hA7, 3'd7};
    vecs[9]  = '{1'b0, 3'd7, 8'h7F, 1'b0, 8'h00, 1'b0, 8'hA7, 3'd7};
    vecs[10] = '{1'b0, 3'd2, 8'h04, 1'b0, 8'h04, 1'b1, 8'hA2, 3'd2};
    vecs[11] = '{1'b0, 3'd3, 8'hFF, 1'b0, 8'h00, 1'b1, 8'hA2, 3'd2};

    rst = 1'b1;
    mode8 = 1'b0; sel8 = '0; in_valid8 = '0; out_ready8 = 1'b1;
    for (int i = 0; i < N8; i++) in_data8[i*W8 +: W8] = 8'(8'hA0 + i);
    mode3 = 1'b0; sel3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    for (int i = 0; i < N3; i++) in_data3[i*W3 +: W3] = 16'(16'hB000 + i);

    tick();
    check("reset_out_valid8", 32'(out_valid8), 32'd0);
    check("reset_out_ch8", 32'(out_ch8), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      mode8 = vecs[v].mode; sel8 = vecs[v].sel;
      in_valid8 = vecs[v].valid; out_ready8 = vecs[v].oready;
      #1;
      check($sformatf("vec%0d_in_ready", v), 32'(in_ready8), 32'(vecs[v].exp_ready));
      tick();
      check($sformatf("vec%0d_out_valid", v), 32'(out_valid8), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_out_data", v), 32'(out_data8), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_out_ch", v), 32'(out_ch8), 32'(vecs[v].exp_ch));
    end

    // Reset while a beat is held and back-pressured.
    rst = 1'b1; mode8 = 1'b1; in_valid8 = 8'hFF; out_ready8 = 1'b0;
    #1;
    check("rst_in_ready8", 32'(in_ready8), 32'd0);
    tick();
    check("rst_out_valid8", 32'(out_valid8), 32'd0);
    check("rst_out_data8", 32'(out_data8), 32'd0);
    check("rst_out_ch8", 32'(out_ch8), 32'd0);
    rst = 1'b0; out_ready8 = 1'b1;

    // Round-robin with all channels requesting: 0..7,0,1.
    for (int k = 0; k < 10; k++) begin
      #1;
      check("rr_in_ready", 32'(in_ready8), 32'(1 << (k % 8)));
      tick();
      check("rr_out_ch", 32'(out_ch8), 32'(k % 8));
      check("rr_out_data", 32'(out_data8), 32'(8'hA0 + (k % 8)));
    end

    // Back-pressure: hold ch1 for five cycles, then drain and reload in one edge.
    out_ready8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_out_valid", 32'(out_valid8), 32'd1);
      check("bp_out_data", 32'(out_data8), 32'hA1);
      check("bp_out_ch", 32'(out_ch8), 32'd1);
      check("bp_in_ready", 32'(in_ready8), 32'd0);
    end
    out_ready8 = 1'b1;
    tick();
    check("bp_release_ch", 32'(out_ch8), 32'd2);
    check("bp_release_valid", 32'(out_valid8), 32'd1);

    // Sparse round-robin on channels 2 and 5.
    in_valid8 = 8'h24;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("sparse_ch", 32'(out_ch8), (k % 2 == 0) ? 32'd5 : 32'd2);
    end

    // Fixed select of an idle channel: no grant, output drains.
    mode8 = 1'b0; sel8 = 3'd7; in_valid8 = 8'h7F;
    #1;
    check("sel7_in_ready", 32'(in_ready8), 32'd0);
    tick();
    check("sel7_out_valid", 32'(out_valid8), 32'd0);
    in_valid8 = '0;

    // Three-channel instance: wrap 0,1,2,0 then out-of-range select.
    mode3 = 1'b1; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("n3_rr_ch", 32'(out_ch3), 32'(k % 3));
      check("n3_rr_data", 32'(out_data3), 32'(16'hB000 + (k % 3)));
    end
    mode3 = 1'b0; sel3 = 2'd3;
    #1;
    check("n3_sel3_in_ready", 32'(in_ready3), 32'd0);
    tick();
    check("n3_sel3_out_valid", 32'(out_valid3), 32'd0);

    // Randomized traffic on both instances against the model.
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      mode8      = 1'($urandom_range(0, 1));
      sel8       = 3'($urandom);
      in_valid8  = 8'($urandom);
      out_ready8 = ($urandom_range(0, 9) < 7);
      in_data8   = {$urandom, $urandom};
      mode3      = 1'($urandom_range(0, 1));
      sel3       = 2'($urandom);
      in_valid3  = 3'($urandom);
      out_ready3 = ($urandom_range(0, 9) < 7);
      in_data3   = 48'({$urandom, $urandom});
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
